uart_encoder: RTL and testbench

- Transmit-side framer feeding the UART TX FIFO; the counterpart of the receive-side decoder on the opponent board.
- Periodically snapshots local game state (sync flags, keeper position, shot coordinates, score) and serialises it into eight opcoded bytes, one byte per opcode 000..111.
- Writes bytes through the FIFO write handshake (wr_uart / tx_full).
- Sits between game_state_sel / mouse_ctl / shoot_ctl / score_ctl and the UART transmitter FIFO.

---
 rtl/uart_encoder.sv | 124 ++++++++++++
 tb/tb_uart_encoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_encoder.sv
// Game-state framer: snapshots local state and writes an eight-byte opcoded
// frame into the UART TX FIFO every FRAME_GAP idle cycles.
module uart_encoder #(
   parameter int FRAME_GAP = 1000,
   parameter int CNT_W     = $clog2(FRAME_GAP + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_enable,
   input  logic       local_shooter,
   input  logic       game_starts,
   input  logic       back_to_start,
   input  logic [9:0] keeper_pos,
   input  logic [9:0] x_shooter,
   input  logic [9:0] y_shooter,
   input  logic [2:0] score_player,
   input  logic       is_scored,
   input  logic       multi_input,
   input  logic       tx_full,
   output logic       wr_uart,
   output logic [7:0] w_data,
   output logic       frame_done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LATCH = 2'd1;
   localparam logic [1:0] SEND  = 2'd2;

   localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(FRAME_GAP);

   logic [1:0]       state;
   logic [CNT_W-1:0] gap_cnt;
   logic [2:0]       idx;
   logic             last_p0;
   logic [7:0]       cur_byte;

   logic       snap_s;
   logic       snap_g;
   logic       snap_b;
   logic [9:0] snap_kp;
   logic [9:0] snap_x;
   logic [9:0] snap_y;
   logic [2:0] snap_sc;
   logic       snap_is;
   logic       snap_mi;

   // back_to_start overrides game_starts in the sync byte
   always_comb begin
      cur_byte = 8'h00;
      case (idx)
         3'd0:    cur_byte = {snap_s & snap_g & ~snap_b, snap_g & ~snap_b, snap_b, 2'b01, 3'b000};
         3'd1:    cur_byte = {snap_kp[4:0], 3'b001};
         3'd2:    cur_byte = {snap_kp[9:5], 3'b010};
         3'd3:    cur_byte = {snap_x[4:0], 3'b011};
         3'd4:    cur_byte = {snap_x[9:5], 3'b100};
         3'd5:    cur_byte = {snap_y[4:0], 3'b101};
         3'd6:    cur_byte = {snap_y[9:5], 3'b110};
         default: cur_byte = {snap_mi, snap_is, snap_sc, 3'b111};
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         gap_cnt    <= '0;
         idx        <= 3'd0;
         last_p0    <= 1'b0;
         wr_uart    <= 1'b0;
         w_data     <= 8'h00;
         frame_done <= 1'b0;
         snap_s     <= 1'b0;
         snap_g     <= 1'b0;
         snap_b     <= 1'b0;
         snap_kp    <= 10'd0;
         snap_x     <= 10'd0;
         snap_y     <= 10'd0;
         snap_sc    <= 3'd0;
         snap_is    <= 1'b0;
         snap_mi    <= 1'b0;
      end else begin
         wr_uart    <= 1'b0;
         last_p0    <= 1'b0;
         frame_done <= last_p0;
         case (state)
            IDLE: begin
               if (gap_cnt == GAP_MAX && tx_enable) begin
                  state   <= LATCH;
                  gap_cnt <= '0;
               end else if (gap_cnt != GAP_MAX) begin
                  gap_cnt <= gap_cnt + CNT_W'(1);
               end
            end
            LATCH: begin
               snap_s  <= local_shooter;
               snap_g  <= game_starts;
               snap_b  <= back_to_start;
               snap_kp <= keeper_pos;
               snap_x  <= x_shooter;
               snap_y  <= y_shooter;
               snap_sc <= score_player;
               snap_is <= is_scored;
               snap_mi <= multi_input;
               idx     <= 3'd0;
               state   <= SEND;
            end
            SEND: begin
               // a full FIFO freezes index and data so nothing is lost or repeated
               if (!tx_full) begin
                  wr_uart <= 1'b1;
                  w_data  <= cur_byte;
                  idx     <= idx + 3'd1;
                  if (idx == 3'd7) begin
                     last_p0 <= 1'b1;
                     gap_cnt <= '0;
                     state   <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_encoder.sv
// Bench for uart_encoder: table-driven frames, stall/coherence/reset sequences
// and randomized frames checked against an arithmetic reference model.
module tb_uart_encoder;

   localparam int GAP = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_enable = 1'b0;
   logic       local_shooter = 1'b0;
   logic       game_starts = 1'b0;
   logic       back_to_start = 1'b0;
   logic [9:0] keeper_pos = '0;
   logic [9:0] x_shooter = '0;
   logic [9:0] y_shooter = '0;
   logic [2:0] score_player = '0;
   logic       is_scored = 1'b0;
   logic       multi_input = 1'b0;
   logic       tx_full = 1'b0;
   logic       wr_uart;
   logic [7:0] w_data;
   logic       frame_done;

   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   bit  rand_full = 1'b0;

   uart_encoder #(.FRAME_GAP(GAP)) dut (
      .clk(clk), .rst(rst), .tx_enable(tx_enable), .local_shooter(local_shooter),
      .game_starts(game_starts), .back_to_start(back_to_start), .keeper_pos(keeper_pos),
      .x_shooter(x_shooter), .y_shooter(y_shooter), .score_player(score_player),
      .is_scored(is_scored), .multi_input(multi_input), .tx_full(tx_full),
      .wr_uart(wr_uart), .w_data(w_data), .frame_done(frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       s, g, b;
      logic [9:0] kp, x, y;
      logic [2:0] sc;
      logic       is, mi;
      logic [7:0] exp [8];
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Byte k of the frame the current inputs should produce.
   function automatic logic [7:0] model_byte(input int k);
      int pay;
      int s, g, b;
      s = int'(local_shooter); g = int'(game_starts); b = int'(back_to_start);
      case (k)
         0: begin
            if (b == 1)      pay = 5;
            else if (g == 0) pay = 1;
            else if (s == 1) pay = 25;
            else             pay = 9;
         end
         1: pay = int'(keeper_pos) % 32;
         2: pay = int'(keeper_pos) / 32;
         3: pay = int'(x_shooter) % 32;
         4: pay = int'(x_shooter) / 32;
         5: pay = int'(y_shooter) % 32;
         6: pay = int'(y_shooter) / 32;
         default: pay = int'(multi_input) * 16 + int'(is_scored) * 8 + int'(score_player);
      endcase
      return 8'(pay * 8 + k);
   endfunction

   task automatic apply(input vec_t v);
      local_shooter = v.s; game_starts = v.g; back_to_start = v.b;
      keeper_pos = v.kp; x_shooter = v.x; y_shooter = v.y;
      score_player = v.sc; is_scored = v.is; multi_input = v.mi;
   endtask

   task automatic get_byte(output logic [7:0] b, output int at);
      b = 8'h00;
      at = -1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (rand_full) tx_full = 1'($urandom_range(0, 1));
         if (wr_uart) begin
            b = w_data;
            at = cyc;
            return;
         end
      end
      errors++;
      checks++;
      $display("FAIL wait_write: got no wr_uart, required one within 400 cycles");
   endtask

   task automatic count_writes(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (wr_uart) cnt++;
      end
   endtask

   task automatic check_done();
      chk("frame_done_low_at_byte7", {31'd0, frame_done}, 32'd0);
      @(negedge clk);
      chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
   endtask

   initial begin
      logic [7:0] b;
      int at, first_at, prev_first, last_at, cnt;
      vec_t v;

      vecs[0] = '{s:1'b1, g:1'b1, b:1'b0, kp:10'h2A5, x:10'h3FF, y:10'h001, sc:3'd3, is:1'b1, mi:1'b0,
                  exp:'{8'hC8, 8'h29, 8'hAA, 8'hFB, 8'hFC, 8'h0D, 8'h06, 8'h5F}};
      vecs[1] = '{s:1'b1, g:1'b1, b:1'b1, kp:10'h2A5, x:10'h3FF, y:10'h001, sc:3'd3, is:1'b1, mi:1'b0,
                  exp:'{8'h28, 8'h29, 8'hAA, 8'hFB, 8'hFC, 8'h0D, 8'h06, 8'h5F}};
      vecs[2] = '{s:1'b0, g:1'b0, b:1'b0, kp:10'h000, x:10'h000, y:10'h3FF, sc:3'd7, is:1'b0, mi:1'b1,
                  exp:'{8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFD, 8'hFE, 8'hBF}};
      vecs[3] = '{s:1'b0, g:1'b1, b:1'b0, kp:10'h3E0, x:10'h01F, y:10'h155, sc:3'd5, is:1'b1, mi:1'b1,
                  exp:'{8'h48, 8'h01, 8'hFA, 8'hFB, 8'h04, 8'hAD, 8'h56, 8'hEF}};

      repeat (3) @(negedge clk);
      chk("reset_wr_uart", {31'd0, wr_uart}, 32'd0);
      chk("reset_w_data", {24'd0, w_data}, 32'd0);
      chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
      rst = 1'b1;

      count_writes(50, cnt);
      chk("idle_disabled_writes", cnt, 0);

      // table of frames, FIFO never full
      prev_first = 0;
      for (int i = 0; i < 4; i++) begin
         apply(vecs[i]);
         tx_enable = 1'b1;
         for (int k = 0; k < 8; k++) begin
            get_byte(b, at);
            if (k == 0) first_at = at;
            chk($sformatf("vec%0d_byte%0d", i, k), {24'd0, b}, {24'd0, vecs[i].exp[k]});
         end
         last_at = at;
         chk($sformatf("vec%0d_back_to_back", i), last_at - first_at, 7);
         if (i > 0) chk($sformatf("vec%0d_period", i), first_at - prev_first, GAP + 10);
         prev_first = first_at;
         check_done();
      end

      // snapshot coherence: keeper changes after byte 1
      apply(vecs[0]);
      for (int k = 0; k < 8; k++) begin
         get_byte(b, at);
         chk($sformatf("coh_byte%0d", k), {24'd0, b}, {24'd0, vecs[0].exp[k]});
         if (k == 1) keeper_pos = 10'h000;
      end
      check_done();
      for (int k = 0; k < 8; k++) begin
         get_byte(b, at);
         chk($sformatf("coh_next_byte%0d", k), {24'd0, b}, {24'd0, model_byte(k)});
      end
      check_done();

      // 3-cycle FIFO stall after byte 2
      apply(vecs[3]);
      for (int k = 0; k < 8; k++) begin
         get_byte(b, at);
         chk($sformatf("stall_byte%0d", k), {24'd0, b}, {24'd0, vecs[3].exp[k]});
         if (k == 2) begin
            tx_full = 1'b1;
            count_writes(3, cnt);
            chk("stall_no_write", cnt, 0);
            tx_full = 1'b0;
         end
      end
      check_done();

      // tx_enable dropped mid-frame: frame completes, no further frame
      apply(vecs[2]);
      for (int k = 0; k < 8; k++) begin
         get_byte(b, at);
         chk($sformatf("drop_byte%0d", k), {24'd0, b}, {24'd0, vecs[2].exp[k]});
         if (k == 3) tx_enable = 1'b0;
      end
      count_writes(60, cnt);
      chk("drop_no_more_frames", cnt, 0);

      // asynchronous reset after byte 4
      apply(vecs[0]);
      tx_enable = 1'b1;
      for (int k = 0; k < 5; k++) get_byte(b, at);
      chk("pre_reset_byte4", {24'd0, b}, {24'd0, vecs[0].exp[4]});
      #2 rst = 1'b0;
      #1;
      chk("async_rst_wr_uart", {31'd0, wr_uart}, 32'd0);
      chk("async_rst_w_data", {24'd0, w_data}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      first_at = cyc;
      for (int k = 0; k < 8; k++) begin
         get_byte(b, at);
         if (k == 0) chk("post_reset_latency", at - first_at, GAP + 3);
         chk($sformatf("post_reset_byte%0d", k), {24'd0, b}, {24'd0, vecs[0].exp[k]});
      end
      check_done();

      // randomized frames with random FIFO back-pressure
      rand_full = 1'b1;
      for (int f = 0; f < 20; f++) begin
         logic [7:0] expf [8];
         for (int k = 0; k < 8; k++) expf[k] = model_byte(k);
         for (int k = 0; k < 8; k++) begin
            get_byte(b, at);
            chk($sformatf("rand%0d_byte%0d", f, k), {24'd0, b}, {24'd0, expf[k]});
            if (k == 3) begin
               v.s = 1'($urandom); v.g = 1'($urandom); v.b = 1'($urandom);
               v.kp = 10'($urandom); v.x = 10'($urandom); v.y = 10'($urandom);
               v.sc = 3'($urandom); v.is = 1'($urandom); v.mi = 1'($urandom);
               apply(v);
            end
         end
      end
      rand_full = 1'b0;
      tx_full = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
